// File: rtl/line_ram_reader.sv
// Read side of a two-line-RAM 3-row window: counts incoming pixels, reads both
// line RAMs at the current column and emits (top, mid, bot) column triples.
module line_ram_reader #(
    parameter int COLUMN_SIZE = 1280,
    parameter int ROW_SIZE    = 1024,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              rama_wren,
    input  logic              ramb_wren,
    input  logic [DATA_W-1:0] pix_in,
    input  logic [DATA_W-1:0] rama_q,
    input  logic [DATA_W-1:0] ramb_q,
    output logic [10:0]       rd_addr,
    output logic              rama_rden,
    output logic              ramb_rden,
    output logic [DATA_W-1:0] row_top,
    output logic [DATA_W-1:0] row_mid,
    output logic [DATA_W-1:0] row_bot,
    output logic              win_valid,
    output logic [10:0]       col_out,
    output logic              line_last,
    output logic              frame_last
);

    localparam int ROW_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, FILL0, FILL1, RUN} state_t;

    state_t           state, state_nxt;
    logic [10:0]      col;
    logic [ROW_W-1:0] row;
    logic             wr, end_of_row, end_of_frame;

    logic              s1_valid, s1_sel_a, s1_eol, s1_eof;
    logic [DATA_W-1:0] s1_pix;
    logic [10:0]       s1_col;

    assign wr           = rama_wren | ramb_wren;
    assign end_of_row   = wr && (col == 11'(COLUMN_SIZE - 1));
    assign end_of_frame = end_of_row && (row == ROW_W'(ROW_SIZE - 1));

    assign rd_addr   = col;
    assign rama_rden = wr;
    assign ramb_rden = wr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr)           state_nxt = FILL0;
            FILL0:   if (end_of_row)   state_nxt = FILL1;
            FILL1:   if (end_of_row)   state_nxt = RUN;
            RUN:     if (end_of_frame) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            if (wr)
                col <= end_of_row ? 11'd0 : col + 11'd1;
            if (end_of_row)
                row <= end_of_frame ? '0 : row + ROW_W'(1);
        end
    end

    // Stage 1: capture the accepted pixel while the RAM read is in flight.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            s1_valid <= 1'b0;
            s1_sel_a <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_pix   <= '0;
            s1_col   <= '0;
        end else begin
            s1_valid <= wr && (state == RUN);
            if (wr) begin
                s1_sel_a <= rama_wren;
                s1_eol   <= end_of_row;
                s1_eof   <= end_of_frame;
                s1_pix   <= pix_in;
                s1_col   <= col;
            end
        end
    end

    // Stage 2: the RAM just written holds the row two above (old data on
    // collision); the other RAM holds the previous row.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            win_valid  <= 1'b0;
            line_last  <= 1'b0;
            frame_last <= 1'b0;
            col_out    <= '0;
            row_top    <= '0;
            row_mid    <= '0;
            row_bot    <= '0;
        end else begin
            win_valid  <= s1_valid;
            line_last  <= s1_valid && s1_eol;
            frame_last <= s1_valid && s1_eof;
            if (s1_valid) begin
                col_out <= s1_col;
                row_bot <= s1_pix;
                row_top <= s1_sel_a ? rama_q : ramb_q;
                row_mid <= s1_sel_a ? ramb_q : rama_q;
            end
        end
    end

endmodule
